// File: rtl/ysyx_210544_cmt_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_cmt_queue_pkg
// Brief    : Shared commit-entry layout and constants for the difftest commit queue.
// Revision : 1.0
// ============================================================================
package ysyx_210544_cmt_queue_pkg;

  localparam int PC_W    = 64;
  localparam int INST_W  = 32;
  localparam int RD_W    = 5;
  localparam int WDATA_W = 64;
  localparam int CODE_W  = 3;
  localparam int WDEST_W = 8;

  localparam logic [6:0] TRAP_OPCODE = 7'h6b;

  typedef struct packed {
    logic               trap;
    logic [CODE_W-1:0]  a0;
    logic               skip;
    logic [WDATA_W-1:0] wdata;
    logic [RD_W-1:0]    rd;
    logic               wen;
    logic [INST_W-1:0]  inst;
    logic [PC_W-1:0]    pc;
  } cmt_entry_t;

  function automatic logic is_trap(input logic [6:0] opcode);
    return opcode == TRAP_OPCODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_210544_cmt_compact.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_cmt_compact
// Brief    : Prefix-sum lane compaction: per-lane tail slot offset and push count.
// Revision : 1.0
// ============================================================================
module ysyx_210544_cmt_compact #(
  parameter int CMT_WIDTH = 2,
  parameter int OFF_W     = $clog2(CMT_WIDTH + 1)
) (
  input  logic [CMT_WIDTH-1:0]            i_valid,
  output logic [CMT_WIDTH-1:0][OFF_W-1:0] o_offset,
  output logic [OFF_W-1:0]                o_count
);

  always_comb begin
    logic [OFF_W-1:0] w_sum;
    w_sum    = '0;
    o_offset = '0;
    for (int k = 0; k < CMT_WIDTH; k++) begin
      o_offset[k] = w_sum;
      w_sum       = w_sum + OFF_W'(i_valid[k]);
    end
    o_count = w_sum;
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_210544_cmt_queue.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_cmt_queue
// Brief    : Difftest commit FIFO with lane compaction, trap/interrupt capture
//            and counters. YSYX_210544_CMT_STATS_EN enables o_stall_cnt.
// Revision : 1.0
// ============================================================================
module ysyx_210544_cmt_queue
  import ysyx_210544_cmt_queue_pkg::*;
#(
  parameter int CMT_WIDTH = 2,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CMT_WIDTH-1:0]         i_cmt_valid,
  input  logic [PC_W*CMT_WIDTH-1:0]    i_cmt_pc,
  input  logic [INST_W*CMT_WIDTH-1:0]  i_cmt_inst,
  input  logic [CMT_WIDTH-1:0]         i_cmt_wen,
  input  logic [RD_W*CMT_WIDTH-1:0]    i_cmt_rd,
  input  logic [WDATA_W*CMT_WIDTH-1:0] i_cmt_wdata,
  input  logic [CMT_WIDTH-1:0]         i_cmt_skip,
  input  logic [63:0]                  i_a0,
  input  logic [31:0]                  i_intr_no,
  output logic                         o_ready,
  input  logic                         i_drain_ready,
  output logic [CMT_WIDTH-1:0]         o_cmt_valid,
  output logic [PC_W*CMT_WIDTH-1:0]    o_cmt_pc,
  output logic [INST_W*CMT_WIDTH-1:0]  o_cmt_inst,
  output logic [CMT_WIDTH-1:0]         o_cmt_wen,
  output logic [WDEST_W*CMT_WIDTH-1:0] o_cmt_wdest,
  output logic [WDATA_W*CMT_WIDTH-1:0] o_cmt_wdata,
  output logic [CMT_WIDTH-1:0]         o_cmt_skip,
  output logic                         o_intr_valid,
  output logic [31:0]                  o_intr_no,
  output logic [63:0]                  o_intr_pc,
  output logic                         o_trap,
  output logic [CODE_W-1:0]            o_trap_code,
  output logic [63:0]                  o_trap_pc,
  output logic [63:0]                  o_cycle_cnt,
  output logic [63:0]                  o_instr_cnt,
  output logic [63:0]                  o_stall_cnt
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_off_w = $clog2(CMT_WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  cmt_entry_t               r_mem [DEPTH];
  logic [c_ptr_w-1:0]       r_head, r_tail;
  logic [c_cnt_w-1:0]       r_count;
  logic                     r_trap;
  logic [CODE_W-1:0]        r_trap_code;
  logic [63:0]              r_trap_pc;
  logic [63:0]              r_cycle_cnt, r_instr_cnt;
  logic                     r_intr_valid;
  logic [31:0]              r_intr_no;
  logic [63:0]              r_intr_pc;

  cmt_entry_t                          w_in_ent   [CMT_WIDTH];
  cmt_entry_t                          w_head_ent [CMT_WIDTH];
  logic [CMT_WIDTH-1:0][c_off_w-1:0]   w_off;
  logic [c_off_w-1:0]                  w_vld_n, w_push_n, w_pop_n;
  logic [CMT_WIDTH-1:0]                w_lane_vld;
  logic                                w_enq, w_trap_hit;
  logic [CODE_W-1:0]                   w_trap_code;
  logic [63:0]                         w_trap_pc;
  logic                                w_unused_a0;

  assign w_unused_a0 = ^i_a0[63:CODE_W];

  ysyx_210544_cmt_compact #(
    .CMT_WIDTH (CMT_WIDTH),
    .OFF_W     (c_off_w)
  ) u_compact (
    .i_valid  (i_cmt_valid),
    .o_offset (w_off),
    .o_count  (w_vld_n)
  );

  // Ready depends only on the registered occupancy.
  assign o_ready  = (c_depth - r_count) >= c_cnt_w'(CMT_WIDTH);
  assign w_enq    = o_ready && (i_intr_no == '0) && !r_trap;
  assign w_push_n = w_enq ? w_vld_n : '0;

  for (genvar k = 0; k < CMT_WIDTH; k++) begin : g_lane
    assign w_in_ent[k] = '{
      trap:  is_trap(i_cmt_inst[k*INST_W +: 7]),
      a0:    i_a0[CODE_W-1:0],
      skip:  i_cmt_skip[k],
      wdata: i_cmt_wdata[k*WDATA_W +: WDATA_W],
      rd:    i_cmt_rd[k*RD_W +: RD_W],
      wen:   i_cmt_wen[k],
      inst:  i_cmt_inst[k*INST_W +: INST_W],
      pc:    i_cmt_pc[k*PC_W +: PC_W]
    };
    assign w_head_ent[k] = r_mem[r_head + c_ptr_w'(k)];

    assign o_cmt_pc[k*PC_W +: PC_W]          = w_lane_vld[k] ? w_head_ent[k].pc : '0;
    assign o_cmt_inst[k*INST_W +: INST_W]    = w_lane_vld[k] ? w_head_ent[k].inst : '0;
    assign o_cmt_wen[k]                      = w_lane_vld[k] && w_head_ent[k].wen;
    assign o_cmt_wdest[k*WDEST_W +: WDEST_W] = w_lane_vld[k] ? WDEST_W'(w_head_ent[k].rd) : '0;
    assign o_cmt_wdata[k*WDATA_W +: WDATA_W] = w_lane_vld[k] ? w_head_ent[k].wdata : '0;
    assign o_cmt_skip[k]                     = w_lane_vld[k] && w_head_ent[k].skip;
  end

  // Lanes younger than the first trap entry are hidden and never popped.
  always_comb begin
    logic w_seen;
    w_seen      = 1'b0;
    w_lane_vld  = '0;
    w_pop_n     = '0;
    w_trap_code = '0;
    w_trap_pc   = '0;
    for (int k = 0; k < CMT_WIDTH; k++) begin
      if (!r_trap && !w_seen && (c_cnt_w'(k) < r_count)) begin
        w_lane_vld[k] = 1'b1;
        w_pop_n       = w_pop_n + c_off_w'(1);
        if (w_head_ent[k].trap) begin
          w_seen      = 1'b1;
          w_trap_code = w_head_ent[k].a0;
          w_trap_pc   = w_head_ent[k].pc;
        end
      end
    end
    if (!i_drain_ready) begin
      w_pop_n = '0;
    end
    w_trap_hit = i_drain_ready && w_seen;
  end

  assign o_cmt_valid = w_lane_vld;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int k = 0; k < CMT_WIDTH; k++) begin
        if (i_cmt_valid[k]) begin
          r_mem[r_tail + c_ptr_w'(w_off[k])] <= w_in_ent[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_trap       <= 1'b0;
      r_trap_code  <= '0;
      r_trap_pc    <= '0;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
      r_intr_valid <= 1'b0;
      r_intr_no    <= '0;
      r_intr_pc    <= '0;
    end else begin
      if (!r_trap) begin
        r_head      <= r_head + c_ptr_w'(w_pop_n);
        r_tail      <= r_tail + c_ptr_w'(w_push_n);
        r_count     <= r_count + c_cnt_w'(w_push_n) - c_cnt_w'(w_pop_n);
        r_cycle_cnt <= r_cycle_cnt + 64'd1;
        r_instr_cnt <= r_instr_cnt + 64'(w_pop_n);
        if (w_trap_hit) begin
          r_trap      <= 1'b1;
          r_trap_code <= w_trap_code;
          r_trap_pc   <= w_trap_pc;
        end
      end
      r_intr_valid <= (i_intr_no != '0);
      if (i_intr_no != '0) begin
        r_intr_no <= i_intr_no;
        r_intr_pc <= i_cmt_pc[PC_W-1:0];
      end
    end
  end

  assign o_trap       = r_trap;
  assign o_trap_code  = r_trap_code;
  assign o_trap_pc    = r_trap_pc;
  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_instr_cnt  = r_instr_cnt;
  assign o_intr_valid = r_intr_valid;
  assign o_intr_no    = r_intr_no;
  assign o_intr_pc    = r_intr_pc;

`ifdef YSYX_210544_CMT_STATS_EN
  logic [63:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!r_trap && ((!o_ready && (i_cmt_valid != '0)) ||
                             ((r_count != '0) && !i_drain_ready))) begin
      r_stall_cnt <= r_stall_cnt + 64'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_210544_cmt_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_210544_cmt_queue
// Brief    : Directed and random stimulus against a queue-based commit model.
// Revision : 1.0
// ============================================================================
module tb_ysyx_210544_cmt_queue;

  localparam int W = 2;
  localparam int D = 8;
`ifdef YSYX_210544_CMT_STATS_EN
  localparam logic [63:0] C_STALL_EXP = 64'd3;
`else
  localparam logic [63:0] C_STALL_EXP = 64'd0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    i_cmt_valid;
  logic [64*W-1:0] i_cmt_pc;
  logic [32*W-1:0] i_cmt_inst;
  logic [W-1:0]    i_cmt_wen;
  logic [5*W-1:0]  i_cmt_rd;
  logic [64*W-1:0] i_cmt_wdata;
  logic [W-1:0]    i_cmt_skip;
  logic [63:0]     i_a0;
  logic [31:0]     i_intr_no;
  logic            i_drain_ready;
  logic            o_ready;
  logic [W-1:0]    o_cmt_valid;
  logic [64*W-1:0] o_cmt_pc;
  logic [32*W-1:0] o_cmt_inst;
  logic [W-1:0]    o_cmt_wen;
  logic [8*W-1:0]  o_cmt_wdest;
  logic [64*W-1:0] o_cmt_wdata;
  logic [W-1:0]    o_cmt_skip;
  logic            o_intr_valid;
  logic [31:0]     o_intr_no;
  logic [63:0]     o_intr_pc;
  logic            o_trap;
  logic [2:0]      o_trap_code;
  logic [63:0]     o_trap_pc;
  logic [63:0]     o_cycle_cnt, o_instr_cnt, o_stall_cnt;

  ysyx_210544_cmt_queue #(.CMT_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .i_cmt_valid(i_cmt_valid), .i_cmt_pc(i_cmt_pc), .i_cmt_inst(i_cmt_inst),
    .i_cmt_wen(i_cmt_wen), .i_cmt_rd(i_cmt_rd), .i_cmt_wdata(i_cmt_wdata),
    .i_cmt_skip(i_cmt_skip), .i_a0(i_a0), .i_intr_no(i_intr_no),
    .o_ready(o_ready), .i_drain_ready(i_drain_ready),
    .o_cmt_valid(o_cmt_valid), .o_cmt_pc(o_cmt_pc), .o_cmt_inst(o_cmt_inst),
    .o_cmt_wen(o_cmt_wen), .o_cmt_wdest(o_cmt_wdest), .o_cmt_wdata(o_cmt_wdata),
    .o_cmt_skip(o_cmt_skip), .o_intr_valid(o_intr_valid), .o_intr_no(o_intr_no),
    .o_intr_pc(o_intr_pc), .o_trap(o_trap), .o_trap_code(o_trap_code),
    .o_trap_pc(o_trap_pc), .o_cycle_cnt(o_cycle_cnt), .o_instr_cnt(o_instr_cnt),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        skip;
    logic [2:0]  a0;
  } ment_t;

  ment_t       q[$];
  logic        m_trap, m_iv;
  logic [2:0]  m_code;
  logic [63:0] m_tpc, m_cycle, m_instr, m_stall, m_ipc;
  logic [31:0] m_ino;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit is_trap_inst(input logic [31:0] inst);
    return inst[6:0] == 7'h6b;
  endfunction

  // Entries the consumer sees: oldest first, up to W, stopping after a trap.
  function automatic int shown_lanes();
    int n = 0;
    if (m_trap) return 0;
    for (int k = 0; k < W && k < q.size(); k++) begin
      n++;
      if (is_trap_inst(q[k].inst)) break;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int    sz, shown;
    bit    rdy, hit;
    ment_t e;
    if (rst) begin
      q.delete();
      m_trap = 0; m_iv = 0; m_code = 0; m_tpc = 0; m_ino = 0; m_ipc = 0;
      m_cycle = 0; m_instr = 0; m_stall = 0;
      return;
    end
    sz    = q.size();
    rdy   = (D - sz) >= W;
    shown = shown_lanes();
    hit   = (shown > 0) && is_trap_inst(q[shown-1].inst);
    if (!m_trap) begin
`ifdef YSYX_210544_CMT_STATS_EN
      if ((!rdy && (i_cmt_valid != 0)) || (sz > 0 && !i_drain_ready)) m_stall++;
`endif
      m_cycle++;
      if (i_drain_ready) begin
        for (int k = 0; k < shown; k++) begin
          e = q.pop_front();
          if (is_trap_inst(e.inst)) begin
            m_code = e.a0;
            m_tpc  = e.pc;
          end
        end
        m_instr += 64'(shown);
      end
      if (rdy && i_intr_no == 0) begin
        for (int k = 0; k < W; k++) begin
          if (i_cmt_valid[k]) begin
            e.pc    = i_cmt_pc[k*64 +: 64];
            e.inst  = i_cmt_inst[k*32 +: 32];
            e.wen   = i_cmt_wen[k];
            e.rd    = i_cmt_rd[k*5 +: 5];
            e.wdata = i_cmt_wdata[k*64 +: 64];
            e.skip  = i_cmt_skip[k];
            e.a0    = i_a0[2:0];
            q.push_back(e);
          end
        end
      end
      if (i_drain_ready && hit) m_trap = 1;
    end
    m_iv = (i_intr_no != 0);
    if (m_iv) begin
      m_ino = i_intr_no;
      m_ipc = i_cmt_pc[63:0];
    end
  endtask

  task automatic check_all();
    int         shown;
    logic [W-1:0] ev;
    ment_t      e;
    shown = shown_lanes();
    ev    = '0;
    for (int k = 0; k < shown; k++) ev[k] = 1'b1;
    chk("ready", 64'(o_ready), 64'((D - q.size()) >= W));
    chk("valid", 64'(o_cmt_valid), 64'(ev));
    for (int k = 0; k < W; k++) begin
      if (k < shown) e = q[k];
      else e = '{default: '0};
      chk($sformatf("pc%0d", k), o_cmt_pc[k*64 +: 64], e.pc);
      chk($sformatf("inst%0d", k), 64'(o_cmt_inst[k*32 +: 32]), 64'(e.inst));
      chk($sformatf("wen%0d", k), 64'(o_cmt_wen[k]), 64'(e.wen));
      chk($sformatf("wdest%0d", k), 64'(o_cmt_wdest[k*8 +: 8]), 64'({3'b000, e.rd}));
      chk($sformatf("wdata%0d", k), o_cmt_wdata[k*64 +: 64], e.wdata);
      chk($sformatf("skip%0d", k), 64'(o_cmt_skip[k]), 64'(e.skip));
    end
    chk("intr_valid", 64'(o_intr_valid), 64'(m_iv));
    chk("intr_no", 64'(o_intr_no), 64'(m_ino));
    chk("intr_pc", o_intr_pc, m_ipc);
    chk("trap", 64'(o_trap), 64'(m_trap));
    chk("trap_code", 64'(o_trap_code), 64'(m_code));
    chk("trap_pc", o_trap_pc, m_tpc);
    chk("cycle_cnt", o_cycle_cnt, m_cycle);
    chk("instr_cnt", o_instr_cnt, m_instr);
    chk("stall_cnt", o_stall_cnt, m_stall);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rand_lanes(input logic [W-1:0] v, input bit allow_trap);
    logic [31:0] inst;
    i_cmt_valid = v;
    for (int k = 0; k < W; k++) begin
      inst = $urandom();
      if (allow_trap && $urandom_range(0, 24) == 0) inst[6:0] = 7'h6b;
      else if (inst[6:0] == 7'h6b) inst[0] = ~inst[0];
      i_cmt_pc[k*64 +: 64]    = {$urandom(), $urandom()};
      i_cmt_inst[k*32 +: 32]  = inst;
      i_cmt_wen[k]            = 1'($urandom());
      i_cmt_rd[k*5 +: 5]      = 5'($urandom());
      i_cmt_wdata[k*64 +: 64] = {$urandom(), $urandom()};
      i_cmt_skip[k]           = 1'($urandom());
    end
    i_a0 = {$urandom(), $urandom()};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_lanes('0, 0);
    i_drain_ready = 1'b0;
    i_intr_no = '0;
    tick();
    rst = 1'b0;
  endtask

  logic [63:0] t_pc, frz_cyc, frz_instr;

  initial begin
    rst = 1'b1;
    i_intr_no = '0;
    i_drain_ready = 1'b0;
    rand_lanes('0, 0);
    tick();
    do_reset();
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_cmt_valid), 64'd0);

    // Only lane 1 valid: compacts into drain lane 0.
    rand_lanes(2'b10, 0);
    i_cmt_pc[127:64] = 64'h8000_0004;
    tick();
    chk("t1_pc", o_cmt_pc[63:0], 64'h8000_0004);
    chk("t1_valid", 64'(o_cmt_valid), 64'd1);
    rand_lanes('0, 0);
    i_drain_ready = 1'b1;
    tick();
    chk("t1_icnt", o_instr_cnt, 64'd1);

    // Fill to DEPTH across the pointer wrap, then drain.
    i_drain_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_lanes(2'b11, 0);
      tick();
    end
    chk("t2_full", 64'(o_ready), 64'd0);
    rand_lanes(2'b11, 0);
    tick();
    rand_lanes('0, 0);
    i_drain_ready = 1'b1;
    tick();
    chk("t2_ready_after_pop", 64'(o_ready), 64'd1);
    for (int c = 0; c < 4; c++) tick();
    chk("t2_empty_valid", 64'(o_cmt_valid), 64'd0);

    // Interrupt cycle enqueues nothing.
    rand_lanes(2'b11, 0);
    i_cmt_pc[63:0] = 64'h8000_0100;
    i_intr_no = 32'd7;
    tick();
    chk("t3_intr_valid", 64'(o_intr_valid), 64'd1);
    chk("t3_intr_no", 64'(o_intr_no), 64'd7);
    chk("t3_intr_pc", o_intr_pc, 64'h8000_0100);
    chk("t3_no_enq", 64'(o_cmt_valid), 64'd0);
    i_intr_no = '0;
    rand_lanes('0, 0);
    tick();
    chk("t3_intr_pulse", 64'(o_intr_valid), 64'd0);

    // Trap in lane 0 masks lane 1, then everything freezes.
    i_drain_ready = 1'b0;
    rand_lanes(2'b11, 0);
    i_cmt_inst[31:0] = 32'h0000_006b;
    i_a0 = 64'h5;
    t_pc = i_cmt_pc[63:0];
    tick();
    chk("t4_masked", 64'(o_cmt_valid), 64'd1);
    frz_instr = o_instr_cnt + 64'd0;
    rand_lanes('0, 0);
    i_drain_ready = 1'b1;
    tick();
    chk("t4_trap", 64'(o_trap), 64'd1);
    chk("t4_code", 64'(o_trap_code), 64'd5);
    chk("t4_pc", o_trap_pc, t_pc);
    chk("t4_icnt", o_instr_cnt, m_instr);
    frz_cyc = m_cycle;
    for (int c = 0; c < 10; c++) begin
      rand_lanes(2'($urandom()), 0);
      i_drain_ready = 1'($urandom());
      tick();
    end
    chk("t4_cyc_frozen", o_cycle_cnt, frz_cyc);
    chk("t4_instr_frozen", o_instr_cnt, m_instr);

    // Steady push 2 / pop 2 at occupancy 3.
    do_reset();
    rand_lanes(2'b11, 0);
    tick();
    rand_lanes(2'b01, 0);
    tick();
    i_drain_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_lanes(2'b11, 0);
      tick();
      chk("t5_valid", 64'(o_cmt_valid), 64'd3);
    end

    // Consumer back-pressure for three cycles.
    do_reset();
    rand_lanes(2'b01, 0);
    tick();
    rand_lanes('0, 0);
    for (int c = 0; c < 3; c++) tick();
    chk("t6_stall", o_stall_cnt, C_STALL_EXP);

    // Random traffic with occasional traps, interrupts and resets.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      rand_lanes(2'($urandom()), 1);
      i_drain_ready = ($urandom_range(0, 9) < 7);
      i_intr_no = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
